branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 23 ++
 rtl/sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and BTB entry.
// Counter states: SNT | strongly not taken, WNT | weakly not taken,
//                 WT  | weakly taken,       ST  | strongly taken
package bp_pkg;

  // Widest tag any legal ENTRIES can need (ENTRIES >= 2 leaves 29 tag bits).
  localparam int TAG_MAX_W = 29;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr_t                 ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Next-state logic for the 2-bit saturating direction counter.
module sat_counter
  import bp_pkg::*;
(
  input  ctr_t state,
  input  logic taken,
  output ctr_t next
);

  always_comb begin
    next = state;
    case (state)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup at fetch,
// table update and registered redirect from the execute-stage resolution.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] LookupPC,
  output logic        Hit,
  output logic        PredTaken,
  output logic [31:0] PredPC,
  input  logic        UpdateEn,
  input  logic [31:0] UpdatePC,
  input  logic        UpdateTaken,
  input  logic [31:0] UpdateTarget,
  input  logic        PredWasTaken,
  input  logic [31:0] PredWasPC,
  input  logic        Invalidate,
  output logic        Mispredict,
  output logic [31:0] RecoverPC
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_MAX_W-1:0] lk_tag;
  btb_entry_t           lk_entry;

  logic [IDX_W-1:0]     up_idx;
  logic [TAG_MAX_W-1:0] up_tag;
  btb_entry_t           up_entry;
  logic                 up_hit;
  ctr_t                 ctr_next;
  logic                 redirect;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{LookupPC[1:0], UpdatePC[1:0]};

  // Tags are zero-extended into the fixed-width struct field.
  assign lk_idx   = LookupPC[IDX_W+1:2];
  assign lk_tag   = TAG_MAX_W'(LookupPC[31:IDX_W+2]);
  assign lk_entry = btb[lk_idx];

  assign Hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign PredTaken = Hit && lk_entry.ctr[1];
  assign PredPC    = PredTaken ? lk_entry.target : LookupPC + 32'd4;

  assign up_idx   = UpdatePC[IDX_W+1:2];
  assign up_tag   = TAG_MAX_W'(UpdatePC[31:IDX_W+2]);
  assign up_entry = btb[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  sat_counter u_sat_counter (
    .state (up_entry.ctr),
    .taken (UpdateTaken),
    .next  (ctr_next)
  );

  assign redirect = UpdateEn &&
                    ((UpdateTaken != PredWasTaken) ||
                     (UpdateTaken && (UpdateTarget != PredWasPC)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      Mispredict <= 1'b0;
      RecoverPC  <= '0;
    end else begin
      if (Invalidate) begin
        // Counters are deliberately kept; only the valid bits drop.
        for (int i = 0; i < ENTRIES; i++) begin
          btb[i].valid <= 1'b0;
        end
      end else if (UpdateEn) begin
        if (up_hit) begin
          btb[up_idx].ctr <= ctr_next;
          if (UpdateTaken) begin
            btb[up_idx].target <= UpdateTarget;
          end
        end else if (UpdateTaken) begin
          btb[up_idx] <= '{valid: 1'b1, tag: up_tag, target: UpdateTarget, ctr: WT};
        end
      end

      Mispredict <= redirect;
      if (redirect) begin
        // Not-taken recovery skips the branch and its delay slot.
        RecoverPC <= UpdateTaken ? UpdateTarget : UpdatePC + 32'd8;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against an array-based BTB model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] LookupPC = '0;
  logic        Hit, PredTaken, Mispredict;
  logic [31:0] PredPC, RecoverPC;
  logic        UpdateEn = 1'b0;
  logic [31:0] UpdatePC = '0;
  logic        UpdateTaken = 1'b0;
  logic [31:0] UpdateTarget = '0;
  logic        PredWasTaken = 1'b0;
  logic [31:0] PredWasPC = '0;
  logic        Invalidate = 1'b0;

  int total = 0;
  int bad   = 0;

  bit        m_valid  [ENTRIES];
  bit [31:0] m_tag    [ENTRIES];
  bit [31:0] m_target [ENTRIES];
  int        m_ctr    [ENTRIES];
  bit        m_misp;
  bit [31:0] m_rec;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .LookupPC     (LookupPC),
    .Hit          (Hit),
    .PredTaken    (PredTaken),
    .PredPC       (PredPC),
    .UpdateEn     (UpdateEn),
    .UpdatePC     (UpdatePC),
    .UpdateTaken  (UpdateTaken),
    .UpdateTarget (UpdateTarget),
    .PredWasTaken (PredWasTaken),
    .PredWasPC    (PredWasPC),
    .Invalidate   (Invalidate),
    .Mispredict   (Mispredict),
    .RecoverPC    (RecoverPC)
  );

  always #5 Clock = ~Clock;

  function automatic int m_index(input bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == (pc >> (2 + IDX_W)));
  endfunction

  function automatic bit m_taken(input bit [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic bit [31:0] m_pred(input bit [31:0] pc);
    return m_taken(pc) ? m_target[m_index(pc)] : pc + 32'd4;
  endfunction

  // Advance one clock edge and apply the edge to the reference model.
  task automatic tick();
    int  i;
    bit  hit, mp;
    @(posedge Clock);
    if (Reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
      end
      m_misp = 0;
      m_rec  = 0;
    end else begin
      i   = m_index(UpdatePC);
      hit = m_hit(UpdatePC);
      mp  = UpdateEn && ((UpdateTaken != PredWasTaken) ||
                         (UpdateTaken && UpdateTarget != PredWasPC));
      if (Invalidate) begin
        for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      end else if (UpdateEn) begin
        if (hit) begin
          if (UpdateTaken) begin
            m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = UpdateTarget;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
        end else if (UpdateTaken) begin
          m_valid[i]  = 1;
          m_tag[i]    = UpdatePC >> (2 + IDX_W);
          m_target[i] = UpdateTarget;
          m_ctr[i]    = 2;
        end
      end
      m_misp = mp;
      if (mp) m_rec = UpdateTaken ? UpdateTarget : UpdatePC + 32'd8;
    end
    #1;
  endtask

  task automatic set_update(input bit en, input bit [31:0] pc, input bit tk,
                            input bit [31:0] tgt, input bit pwt, input bit [31:0] pwpc);
    UpdateEn = en; UpdatePC = pc; UpdateTaken = tk; UpdateTarget = tgt;
    PredWasTaken = pwt; PredWasPC = pwpc;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    LookupPC = 32'h0040_0010;
    #1;
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b exp=0", Hit); end
    total++; if (PredTaken !== 1'b0) begin bad++; $display("FAIL reset_predtaken got=%0b exp=0", PredTaken); end
    total++; if (PredPC !== 32'h0040_0014) begin bad++; $display("FAIL reset_predpc got=%h exp=00400014", PredPC); end
    total++; if (Mispredict !== 1'b0) begin bad++; $display("FAIL reset_misp got=%0b exp=0", Mispredict); end
    total++; if (RecoverPC !== 32'h0) begin bad++; $display("FAIL reset_recpc got=%h exp=0", RecoverPC); end
  endtask

  task automatic test_allocate();
    set_update(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0014);
    tick();
    set_update(0, 0, 0, 0, 0, 0);
    total++; if (Mispredict !== 1'b1) begin bad++; $display("FAIL alloc_misp got=%0b exp=1", Mispredict); end
    total++; if (RecoverPC !== 32'h0040_0100) begin bad++; $display("FAIL alloc_recpc got=%h exp=00400100", RecoverPC); end
    LookupPC = 32'h0040_0010;
    #1;
    total++; if (Hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%0b exp=1", Hit); end
    total++; if (PredTaken !== 1'b1) begin bad++; $display("FAIL alloc_predtaken got=%0b exp=1", PredTaken); end
    total++; if (PredPC !== 32'h0040_0100) begin bad++; $display("FAIL alloc_predpc got=%h exp=00400100", PredPC); end
    tick();
    total++; if (Mispredict !== 1'b0) begin bad++; $display("FAIL alloc_misp_clear got=%0b exp=0", Mispredict); end
  endtask

  task automatic test_counter();
    LookupPC = 32'h0040_0010;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) set_update(1, 32'h0040_0010, 0, 32'h0, 1, 32'h0040_0100);
      else        set_update(1, 32'h0040_0010, 0, 32'h0, 0, 32'h0040_0014);
      tick();
      set_update(0, 0, 0, 0, 0, 0);
      #1;
      total++; if (Mispredict !== (n == 0)) begin bad++; $display("FAIL ctr_misp%0d got=%0b exp=%0b", n, Mispredict, n == 0); end
      total++; if (Hit !== 1'b1 || PredTaken !== 1'b0) begin bad++; $display("FAIL ctr_pred%0d got=%0b%0b exp=10", n, Hit, PredTaken); end
      total++; if (PredPC !== 32'h0040_0014) begin bad++; $display("FAIL ctr_predpc%0d got=%h exp=00400014", n, PredPC); end
    end
    total++; if (RecoverPC !== 32'h0040_0018) begin bad++; $display("FAIL ctr_recpc got=%h exp=00400018", RecoverPC); end
    // From SNT one taken update reaches only WNT, so still predicted not taken.
    set_update(1, 32'h0040_0010, 1, 32'h0040_0200, 0, 32'h0040_0014);
    tick();
    set_update(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (PredTaken !== 1'b0) begin bad++; $display("FAIL ctr_sat_low got=%0b exp=0", PredTaken); end
    total++; if (RecoverPC !== 32'h0040_0200) begin bad++; $display("FAIL ctr_recpc2 got=%h exp=00400200", RecoverPC); end
  endtask

  task automatic test_alias();
    set_update(1, 32'h0080_0010, 1, 32'h0080_0300, 0, 32'h0080_0014);
    tick();
    set_update(0, 0, 0, 0, 0, 0);
    LookupPC = 32'h0040_0010;
    #1;
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL alias_old_hit got=%0b exp=0", Hit); end
    LookupPC = 32'h0080_0010;
    #1;
    total++; if (Hit !== 1'b1) begin bad++; $display("FAIL alias_new_hit got=%0b exp=1", Hit); end
    total++; if (PredPC !== 32'h0080_0300) begin bad++; $display("FAIL alias_predpc got=%h exp=00800300", PredPC); end
  endtask

  task automatic test_same_cycle();
    LookupPC = 32'h00C0_0020;
    set_update(1, 32'h00C0_0020, 1, 32'h00C0_0400, 0, 32'h00C0_0024);
    #1;
    total++; if (Hit !== 1'b0 || PredPC !== 32'h00C0_0024) begin bad++; $display("FAIL same_cycle_pre got=%0b/%h exp=0/00c00024", Hit, PredPC); end
    tick();
    set_update(0, 0, 0, 0, 0, 0);
    #1;
    total++; if (Hit !== 1'b1 || PredPC !== 32'h00C0_0400) begin bad++; $display("FAIL same_cycle_post got=%0b/%h exp=1/00c00400", Hit, PredPC); end
  endtask

  task automatic test_invalidate();
    Invalidate = 1'b1;
    set_update(1, 32'h0080_0010, 1, 32'h0123_4560, 1, 32'h0080_0300);
    tick();
    Invalidate = 1'b0;
    set_update(0, 0, 0, 0, 0, 0);
    total++; if (Mispredict !== 1'b1) begin bad++; $display("FAIL inval_misp got=%0b exp=1", Mispredict); end
    total++; if (RecoverPC !== 32'h0123_4560) begin bad++; $display("FAIL inval_recpc got=%h exp=01234560", RecoverPC); end
    foreach (m_valid[k]) begin
      LookupPC = 32'h0080_0000 | (k << 2);
      #1;
      total++; if (Hit !== 1'b0) begin bad++; $display("FAIL inval_hit%0d got=%0b exp=0", k, Hit); end
    end
    LookupPC = 32'h00C0_0020;
    #1;
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL inval_hit_c got=%0b exp=0", Hit); end
  endtask

  task automatic test_reset_update();
    set_update(1, 32'h0040_0010, 1, 32'h0040_0100, 0, 32'h0040_0014);
    tick();
    Reset = 1'b1;
    set_update(1, 32'h0050_0010, 1, 32'h0050_0100, 0, 32'h0050_0014);
    tick();
    Reset = 1'b0;
    set_update(0, 0, 0, 0, 0, 0);
    LookupPC = 32'h0050_0010;
    #1;
    total++; if (Mispredict !== 1'b0) begin bad++; $display("FAIL rst_upd_misp got=%0b exp=0", Mispredict); end
    total++; if (RecoverPC !== 32'h0) begin bad++; $display("FAIL rst_upd_recpc got=%h exp=0", RecoverPC); end
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL rst_upd_hit got=%0b exp=0", Hit); end
    LookupPC = 32'h0040_0010;
    #1;
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL rst_upd_hit2 got=%0b exp=0", Hit); end
  endtask

  task automatic test_random();
    bit [31:0] pc, tgt;
    for (int n = 0; n < 400; n++) begin
      LookupPC = 32'h1000_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      pc  = 32'h1000_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      tgt = 32'h2000_0000 | ($urandom_range(0, 7) << 4);
      UpdateEn     = ($urandom_range(0, 9) < 7);
      UpdatePC     = pc;
      UpdateTaken  = $urandom_range(0, 1);
      UpdateTarget = tgt;
      if ($urandom_range(0, 3) != 0) begin
        PredWasTaken = m_taken(pc);
        PredWasPC    = m_pred(pc);
      end else begin
        PredWasTaken = $urandom_range(0, 1);
        PredWasPC    = 32'h2000_0000 | ($urandom_range(0, 7) << 4);
      end
      Invalidate = ($urandom_range(0, 39) == 0);
      Reset      = ($urandom_range(0, 99) == 0);
      #1;
      total++; if (Hit !== m_hit(LookupPC)) begin bad++; $display("FAIL rnd_hit n=%0d got=%0b exp=%0b", n, Hit, m_hit(LookupPC)); end
      total++; if (PredTaken !== m_taken(LookupPC)) begin bad++; $display("FAIL rnd_taken n=%0d got=%0b exp=%0b", n, PredTaken, m_taken(LookupPC)); end
      total++; if (PredPC !== m_pred(LookupPC)) begin bad++; $display("FAIL rnd_predpc n=%0d got=%h exp=%h", n, PredPC, m_pred(LookupPC)); end
      tick();
      total++; if (Mispredict !== m_misp) begin bad++; $display("FAIL rnd_misp n=%0d got=%0b exp=%0b", n, Mispredict, m_misp); end
      total++; if (RecoverPC !== m_rec) begin bad++; $display("FAIL rnd_recpc n=%0d got=%h exp=%h", n, RecoverPC, m_rec); end
    end
    Reset = 1'b0; Invalidate = 1'b0;
    set_update(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_invalidate();
    test_reset_update();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
